// File: rtl/reg_wb_pkg.sv
// Shared op codes, FSM states and constants for the writeback controller.
// REG_WB_LINK_EN enables OP_LINK (PC+8) writes.
package reg_wb_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ALU  = 3'd0;
  localparam op_t OP_WORD = 3'd1;
  localparam op_t OP_BYTE = 3'd2;
  localparam op_t OP_HALF = 3'd3;
  localparam op_t OP_IMM  = 3'd4;
  localparam op_t OP_LINK = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_WRITE
  } state_t;

  localparam int LINK_OFFSET = 8;

  function automatic logic is_load(input op_t op);
    return (op == OP_WORD) || (op == OP_BYTE) ||
           (op == OP_HALF);
  endfunction

endpackage

// File: rtl/reg_wb_ctrl_load_extend.sv
// Little-endian lane select and sign/zero extension of load data.
// Halfword selection uses only byte_off[1].
module load_extend
  import reg_wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  op_t               op_i,
  input  logic              sign_i,
  input  logic [1:0]        byte_off_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata_i[7:0];
    unique case (byte_off_i)
      2'd0: b = rdata_i[7:0];
      2'd1: b = rdata_i[15:8];
      2'd2: b = rdata_i[23:16];
      2'd3: b = rdata_i[31:24];
      default: b = rdata_i[7:0];
    endcase
    h = byte_off_i[1] ? rdata_i[31:16]
                      : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    unique case (1'b1)
      (op_i == OP_BYTE):
        data_o = {{(DATA_W-8){sign_i & b[7]}}, b};
      (op_i == OP_HALF):
        data_o = {{(DATA_W-16){sign_i & h[15]}}, h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file writeback controller with load wait and timeout.
// Define REG_WB_LINK_EN to build the OP_LINK (PC+8) path.
module reg_wb_ctrl
  import reg_wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_op,
  input  logic              i_sign,
  input  logic [1:0]        i_byte_off,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [15:0]       i_imm,
  input  logic [DATA_W-1:0] i_pc,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_wen,
  output logic [REG_AW-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_busy,
  output logic              o_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT_CYC - 1);

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  op_t               op_q;
  logic              sign_q;
  logic [1:0]        off_q;
  logic [REG_AW-1:0] rd_q;
  logic              wen_q;
  logic              err_q;
  logic [REG_AW-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              op_legal;
  logic [DATA_W-1:0] nl_data;
  logic [DATA_W-1:0] ext_data;

  load_extend #(.DATA_W(DATA_W)) u_ext (
    .rdata_i    (i_mem_rdata),
    .op_i       (op_q),
    .sign_i     (sign_q),
    .byte_off_i (off_q),
    .data_o     (ext_data)
  );

`ifdef REG_WB_LINK_EN
  logic [DATA_W-1:0] link_data;
  assign link_data = i_pc + DATA_W'(LINK_OFFSET);
  assign op_legal  = (i_op <= OP_LINK);
`else
  logic unused_pc;
  assign unused_pc = ^i_pc;
  assign op_legal  = (i_op <= OP_IMM);
`endif

  always_comb begin
    nl_data = i_alu_result;
    unique case (1'b1)
      (i_op == OP_IMM):
        nl_data = {i_imm, {(DATA_W-16){1'b0}}};
`ifdef REG_WB_LINK_EN
      (i_op == OP_LINK):
        nl_data = link_data;
`endif
      default: nl_data = i_alu_result;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ALU;
      sign_q  <= 1'b0;
      off_q   <= 2'd0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        S_WAIT_MEM: begin
          // a response in the expiry cycle still wins
          if (i_mem_rvalid) begin
            state_q <= S_WRITE;
            wen_q   <= (rd_q != '0);
            waddr_q <= rd_q;
            wdata_q <= ext_data;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (!i_valid) begin
            state_q <= S_IDLE;
          end else if (!op_legal) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
          end else if (is_load(i_op)) begin
            state_q <= S_WAIT_MEM;
            cnt_q   <= '0;
            op_q    <= i_op;
            sign_q  <= i_sign;
            off_q   <= i_byte_off;
            rd_q    <= i_rd;
          end else begin
            state_q <= S_WRITE;
            wen_q   <= (i_rd != '0);
            waddr_q <= i_rd;
            wdata_q <= nl_data;
          end
        end
      endcase
    end
  end

  assign o_ready = (state_q != S_WAIT_MEM);
  assign o_busy  = (state_q == S_WAIT_MEM);
  assign o_wen   = wen_q;
  assign o_err   = err_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Scoreboard bench for reg_wb_ctrl: expected writes queued at issue.
module tb_reg_wb_ctrl;
  import reg_wb_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_op = 3'd0;
  logic        i_sign = 1'b0;
  logic [1:0]  i_byte_off = 2'd0;
  logic [4:0]  i_rd = 5'd0;
  logic [31:0] i_alu_result = '0;
  logic [15:0] i_imm = '0;
  logic [31:0] i_pc = '0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_wen;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic        o_busy;
  logic        o_err;

  int errors = 0;
  int checks = 0;
  logic [36:0] sb[$];

  reg_wb_ctrl #(
    .DATA_W(32), .REG_AW(5), .TIMEOUT_CYC(16)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_sign(i_sign),
    .i_byte_off(i_byte_off), .i_rd(i_rd),
    .i_alu_result(i_alu_result), .i_imm(i_imm),
    .i_pc(i_pc), .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata), .o_wen(o_wen),
    .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  always @(negedge clock) begin
    if (reset_n && o_wen) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: addr=%0d data=%h",
                 o_waddr, o_wdata);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        if ({o_waddr, o_wdata} !== e) begin
          errors++;
          $display("FAIL sb_write: got %0d/%h want %0d/%h",
                   o_waddr, o_wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] op,
                       input logic [4:0] rd,
                       input logic [31:0] alu,
                       input logic [15:0] imm,
                       input logic [31:0] pc,
                       input logic sign,
                       input logic [1:0] off);
    i_valid = 1'b1;
    i_op = op;
    i_rd = rd;
    i_alu_result = alu;
    i_imm = imm;
    i_pc = pc;
    i_sign = sign;
    i_byte_off = off;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wen"}, 32'(o_wen), 32'd0);
    chk({tag, "_waddr"}, 32'(o_waddr), 32'd0);
    chk({tag, "_wdata"}, o_wdata, 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    drive(OP_ALU, 5'd3, 32'h1234, 16'h0, 32'h0,
          1'b0, 2'd0);
    sb.push_back({5'd3, 32'h0000_1234});
    tick();
    chk("b2b_wen0", 32'(o_wen), 32'd1);
    chk("b2b_addr0", 32'(o_waddr), 32'd3);
    drive(OP_IMM, 5'd4, 32'h0, 16'hABCD, 32'h0,
          1'b0, 2'd0);
    sb.push_back({5'd4, 32'hABCD_0000});
    tick();
    i_valid = 1'b0;
    chk("b2b_wen1", 32'(o_wen), 32'd1);
    chk("b2b_data1", o_wdata, 32'hABCD_0000);
    tick();
    chk("b2b_idle", 32'(o_wen), 32'd0);
  endtask

  task automatic load_test(input string name,
                           input logic [2:0] op,
                           input logic [1:0] off,
                           input logic sign,
                           input logic [31:0] rdata,
                           input int delay,
                           input logic [31:0] exp);
    int nbusy = 0;
    drive(op, 5'd9, 32'h0, 16'h0, 32'h0, sign, off);
    sb.push_back({5'd9, exp});
    tick();
    i_valid = 1'b0;
    for (int i = 1; i <= delay; i++) begin
      if (o_busy === 1'b1 && o_ready === 1'b0
          && o_wen === 1'b0 && o_err === 1'b0)
        nbusy++;
      if (i == delay) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata = rdata;
      end
      tick();
      i_mem_rvalid = 1'b0;
      i_mem_rdata = 32'h0;
    end
    chk({name, "_busy_cycles"}, 32'(nbusy), 32'(delay));
    chk({name, "_wen"}, 32'(o_wen), 32'd1);
    chk({name, "_data"}, o_wdata, exp);
    chk({name, "_err"}, 32'(o_err), 32'd0);
    tick();
  endtask

  task automatic test_loads();
    load_test("byte_s", OP_BYTE, 2'd3, 1'b1,
              32'h80FF_0000, 5, 32'hFFFF_FF80);
    load_test("byte_z", OP_BYTE, 2'd3, 1'b0,
              32'h80FF_0000, 5, 32'h0000_0080);
    load_test("byte_o1", OP_BYTE, 2'd1, 1'b1,
              32'h0000_7F00, 2, 32'h0000_007F);
    load_test("byte_o0", OP_BYTE, 2'd0, 1'b1,
              32'h1234_56A5, 1, 32'hFFFF_FFA5);
    load_test("half_s", OP_HALF, 2'd2, 1'b1,
              32'h8001_7FFF, 3, 32'hFFFF_8001);
    load_test("half_z3", OP_HALF, 2'd3, 1'b0,
              32'h8001_7FFF, 1, 32'h0000_8001);
    load_test("half_o1", OP_HALF, 2'd1, 1'b1,
              32'h8001_7FFF, 1, 32'h0000_7FFF);
    load_test("word", OP_WORD, 2'd2, 1'b1,
              32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
    load_test("race", OP_WORD, 2'd0, 1'b0,
              32'h0BAD_F00D, 16, 32'h0BAD_F00D);
  endtask

  task automatic test_timeout();
    int n = 0;
    int early_err = 0;
    drive(OP_WORD, 5'd5, 32'h0, 16'h0, 32'h0,
          1'b0, 2'd0);
    tick();
    i_valid = 1'b0;
    while (o_busy === 1'b1 && n < 40) begin
      if (o_err !== 1'b0 || o_wen !== 1'b0)
        early_err++;
      n++;
      tick();
    end
    chk("to_busy_cycles", 32'(n), 32'd16);
    chk("to_early", 32'(early_err), 32'd0);
    chk("to_err", 32'(o_err), 32'd1);
    chk("to_wen", 32'(o_wen), 32'd0);
    chk("to_ready", 32'(o_ready), 32'd1);
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'hFFFF_FFFF;
    tick();
    i_mem_rvalid = 1'b0;
    chk("to_pulse", 32'(o_err), 32'd0);
    tick();
    chk("to_late_wen", 32'(o_wen), 32'd0);
    chk("to_late_busy", 32'(o_busy), 32'd0);
  endtask

  task automatic test_reg0_illegal();
    drive(OP_ALU, 5'd0, 32'h55, 16'h0, 32'h0,
          1'b0, 2'd0);
    tick();
    i_valid = 1'b0;
    chk("r0_wen", 32'(o_wen), 32'd0);
    chk("r0_waddr", 32'(o_waddr), 32'd0);
    chk("r0_wdata", o_wdata, 32'h55);
    tick();
    drive(3'd7, 5'd6, 32'h77, 16'h0, 32'h0,
          1'b0, 2'd0);
    tick();
    i_valid = 1'b0;
    chk("ill_err", 32'(o_err), 32'd1);
    chk("ill_wen", 32'(o_wen), 32'd0);
    chk("ill_ready", 32'(o_ready), 32'd1);
    tick();
    chk("ill_pulse", 32'(o_err), 32'd0);
    drive(OP_LINK, 5'd31, 32'h0, 16'h0, 32'hFFFF_FFFC,
          1'b0, 2'd0);
`ifdef REG_WB_LINK_EN
    sb.push_back({5'd31, 32'h0000_0004});
`endif
    tick();
    i_valid = 1'b0;
`ifdef REG_WB_LINK_EN
    chk("link_wen", 32'(o_wen), 32'd1);
    chk("link_data", o_wdata, 32'h0000_0004);
    chk("link_err", 32'(o_err), 32'd0);
`else
    chk("link_err", 32'(o_err), 32'd1);
    chk("link_wen", 32'(o_wen), 32'd0);
`endif
    tick();
  endtask

  task automatic test_reset_midload();
    drive(OP_ALU, 5'd7, 32'hCAFE_0001, 16'h0, 32'h0,
          1'b0, 2'd0);
    sb.push_back({5'd7, 32'hCAFE_0001});
    tick();
    drive(OP_WORD, 5'd8, 32'h0, 16'h0, 32'h0,
          1'b0, 2'd0);
    tick();
    i_valid = 1'b0;
    tick();
    chk("rml_busy", 32'(o_busy), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_reset_vals("rml_rst");
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'h1111_2222;
    tick();
    i_mem_rvalid = 1'b0;
    tick();
    check_reset_vals("rml_after");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_loads();
    test_timeout();
    test_reg0_illegal();
    test_reset_midload();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
